// File: rtl/spart_pkg.sv
// Shared SPART types and constants used by the transmit scheduler and baud generator.
package spart_pkg;

    localparam int SPART_DATA_W = 8;
    localparam int SPART_DIV_W  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_sched_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud tick generator: one-cycle pulse every `div` clocks; div = 0 stops ticks.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter int DIV_W = SPART_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    output logic             baud_enable
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             baud_q;
    logic             baud_d;

    // Next counter value; divisor is only sampled on reload so a change never truncates a period.
    always_comb begin
        cnt_d  = cnt_q;
        baud_d = 1'b0;
        if (div == {DIV_W{1'b0}}) begin
            cnt_d  = {DIV_W{1'b0}};
            baud_d = 1'b0;
        end else if (cnt_q == {DIV_W{1'b0}}) begin
            cnt_d  = div - {{(DIV_W-1){1'b0}}, 1'b1};
            baud_d = 1'b1;
        end else begin
            cnt_d  = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
            baud_d = 1'b0;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= {DIV_W{1'b0}};
            baud_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            baud_q <= baud_d;
        end
    end

    assign baud_enable = baud_q;

endmodule

// File: rtl/spart_tx_sched.sv
// SPART transmit scheduler: round-robin between two byte requesters, loads the
// transmitter one byte at a time by tracking tbr, and hosts the baud generator.
module spart_tx_sched
    import spart_pkg::*;
#(
    parameter int DATA_W = SPART_DATA_W,
    parameter int DIV_W  = SPART_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              ack0,
    output logic              ack1,
    input  logic              tbr,
    output logic              t_enable,
    output logic [DATA_W-1:0] tx_data,
    output logic              baud_enable,
    output logic              busy
);

    tx_sched_state_t   state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              t_enable_q, t_enable_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              grant1;

    // Next-state, arbitration and load-strobe generation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        t_enable_d   = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        tx_data_d    = tx_data_q;
        // Port 1 wins when alone, or on a tie when port 0 was served last.
        grant1       = req1 & (~req0 | ~last_grant_q);
        case (state_q)
            IDLE: begin
                if (tbr && (req0 || req1)) begin
                    t_enable_d   = 1'b1;
                    last_grant_d = grant1;
                    if (grant1) begin
                        tx_data_d = data1;
                        ack1_d    = 1'b1;
                    end else begin
                        tx_data_d = data0;
                        ack0_d    = 1'b1;
                    end
                    state_d = WAIT_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (!tbr) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (tbr) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered output flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            t_enable_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            tx_data_q    <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            t_enable_q   <= t_enable_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            tx_data_q    <= tx_data_d;
        end
    end

    spart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .div        (div),
        .baud_enable(baud_enable)
    );

    assign t_enable = t_enable_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/spart_tx_sched.md
# spart_tx_sched

Transmit-side controller for the SPART UART transmitter. It generates the transmitter's `baud_enable` tick from a programmable divisor and shares the single transmitter between two byte requesters. Requesters are port 0 (processor/bus write path) and port 1 (receive-echo path), arbitrated round-robin. It drives the transmitter's `t_enable`/`data` load strobe and tracks `tbr` to sequence one byte at a time. It sits between the SPART bus interface and the transmitter.

## Interface
Parameters:
- `DATA_W`, 8, byte width driven to the transmitter.
- `DIV_W`, 16, width of the baud divisor.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low (0 = reset).
- `div`  in  DIV_W  clocks per baud tick; 0 disables ticks.
- `req0`, `req1`  in  1  byte request; held high with data stable until the matching ack.
- `data0`, `data1`  in  DATA_W  byte to send.
- `ack0`, `ack1`  out  1  one-cycle pulse: byte accepted and loaded into the transmitter.
- `tbr`  in  1  transmitter buffer ready (1 = idle, can load).
- `t_enable`  out  1  one-cycle load strobe to the transmitter.
- `tx_data`  out  DATA_W  byte to the transmitter; valid while `t_enable` = 1, held afterwards.
- `baud_enable`  out  1  one-cycle baud tick to the transmitter.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- **Reset values** (edge with `rst` = 0):
  - all outputs 0.
  - state = IDLE.
  - `last_grant` = 1, so port 0 wins the first tie.
  - baud counter = 0.
- **FSM, states IDLE, WAIT_BUSY, WAIT_DONE:**
  - IDLE: if `tbr` = 1 and any req is high, grant one port.
    - Registered outputs: `t_enable` = 1, `tx_data` = granted data, granted ack = 1, `last_grant` = granted index.
    - Go to WAIT_BUSY.
    - If `tbr` = 0, no grant regardless of requests.
  - WAIT_BUSY: `t_enable` and ack return to 0. Stay until `tbr` = 0, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tbr` = 1, then go to IDLE.
- **Arbitration:**
  - Only one request high: grant it.
  - Both high: grant the port not equal to `last_grant`.
  - Requests are sampled only in IDLE. A req dropped before grant is simply not granted; no error.
- **Baud generator:**
  - Counter `cnt` (DIV_W bits). Each edge with `div` != 0:
    - if `cnt` = 0: `baud_enable` <= 1 and `cnt` <= `div` - 1;
    - else: `baud_enable` <= 0 and `cnt` <= `cnt` - 1.
  - `div` = 0: `baud_enable` <= 0 and `cnt` <= 0.
  - A `div` change takes effect at the next reload; the current period is not truncated.
  - Arithmetic is unsigned, DIV_W wide.
- `busy` = (state != IDLE), combinational from the state register.

## Timing
- Grant latency: request seen at edge k in IDLE with `tbr` = 1, so `t_enable`, ack and `tx_data` are high/valid in cycle k..k+1. This is exactly one cycle.
- Minimum spacing between loads: load edge, `tbr` fall edge, `tbr` rise edge, then the next grant at the earliest following edge.
- Simultaneous requests plus `tbr` rising in WAIT_DONE: return to IDLE first. The grant happens one edge later, never in the same edge.
- Baud tick period = `div` clocks, pulse width one clock. With `div` = 1, `baud_enable` is continuously high.
- First tick after reset: first active edge with `div` != 0, because the counter resets to 0.
- Reset mid-operation (any state): next edge forces IDLE, with `t_enable`, ack and `baud_enable` at 0. No pending ack is issued afterwards. The transmitter is reset by its own reset.

## Structure
- Shared package `spart_pkg`:
  - state enum `tx_sched_state_t` {IDLE, WAIT_BUSY, WAIT_DONE};
  - constants `SPART_DATA_W` = 8 and `SPART_DIV_W` = 16.
- Sub-module `spart_baud_gen` (inputs `clk`, `rst`, `div`; output `baud_enable`), instantiated once. It is reused later by the receiver side.
- Arbiter and FSM stay in the top module.

## Test plan
- Reset: `rst` = 0 for 3 clocks with `req0` = 1 and `div` = 4 → all outputs 0, `busy` = 0, no ack.
- Single send: `req0` = 1, `data0` = 8'hFE, `tbr` = 1.
  - Expect `t_enable` = 1, `tx_data` = 8'hFE and `ack0` = 1 for exactly one cycle.
  - `busy` stays 1 until `tbr` falls then rises, then returns to 0.
- Round-robin after reset: both reqs held, `data0` = 8'h11, `data1` = 8'h22.
  - Loads occur in order 8'h11, 8'h22, 8'h11; acks alternate.
- Busy transmitter: `tbr` = 0 in IDLE with `req1` = 1 for 10 cycles → no `t_enable`. After `tbr` = 1, grant on the next edge.
- Baud:
  - `div` = 4 → `baud_enable` pulses every 4th clock, one cycle wide.
  - `div` = 0 → no pulses.
  - `div` = 1 → constant 1.
  - `div` changed 4 → 2 mid-period → the current period completes at 4, then the period is 2.
- Reset mid-transfer: `rst` = 0 during WAIT_DONE → next edge `busy` = 0, `t_enable` = 0. No ack after reset release until a new request is granted.
